seq_chunk_adder: RTL

- Multi-cycle sequencer that computes a wide add or subtract by time-multiplexing one narrow exact ripple-carry adder stage.
- Processes one CHUNK-wide slice per cycle, least-significant slice first, and registers the carry between slices.
- Lets approximate-arithmetic datapaths wider than the synthesized adder reuse a small adder.
- Ready/valid on both input and output; one operation in flight.

---
 rtl/seq_chunk_adder_if.sv | 27 ++
 rtl/seq_chunk_adder.sv | 105 ++++++++++
 2 files changed

// File: rtl/seq_chunk_adder_if.sv
// Ready/valid request/response bundle for seq_chunk_adder.
// The master drives operands and accepts results; the slave is the sequencer.
interface seq_chunk_adder_if #(
  parameter int width = 128
);
  logic             in_valid;
  logic             in_ready;
  logic [width-1:0] a;
  logic [width-1:0] b;
  logic             cin;
  logic             sub;
  logic             out_valid;
  logic             out_ready;
  logic [width-1:0] s;
  logic             cout;
  logic             busy;

  modport master (
    output in_valid, a, b, cin, sub, out_ready,
    input  in_ready, out_valid, s, cout, busy
  );

  modport slave (
    input  in_valid, a, b, cin, sub, out_ready,
    output in_ready, out_valid, s, cout, busy
  );
endinterface

// File: rtl/seq_chunk_adder.sv
// Wide add/subtract built by time-multiplexing one chunk-wide ripple adder,
// least-significant slice first, with the carry registered between slices.
module seq_chunk_adder #(
  parameter int width = 128,
  parameter int chunk = 32
) (
  input  logic              clock,
  input  logic              reset,
  seq_chunk_adder_if.slave  bus
);
  localparam int n  = width / chunk;
  localparam int iw = (n > 1) ? $clog2(n) : 1;
  localparam logic [iw-1:0] last_idx = iw'(n - 1);

  typedef enum logic [1:0] {IDLE, ADD, DONE} state_t;

  state_t           state;
  logic [width-1:0] opa;
  logic [width-1:0] opb;
  logic [width-1:0] res;
  logic             carry;
  logic [iw-1:0]    idx;

  logic             in_ready_q;
  logic             out_valid_q;
  logic             busy_q;
  logic [width-1:0] s_q;
  logic             cout_q;

  logic [chunk-1:0] slice_a;
  logic [chunk-1:0] slice_b;
  logic [chunk-1:0] slice_r;
  logic             slice_c;
  logic [width-1:0] res_next;

  // NOTE: every output of this block gets a default first, so no path leaves a latch.
  always_comb begin
    slice_a  = opa[int'(idx)*chunk +: chunk];
    slice_b  = opb[int'(idx)*chunk +: chunk];
    {slice_c, slice_r} = {1'b0, slice_a} + {1'b0, slice_b} + {{chunk{1'b0}}, carry};
    res_next = res;
    res_next[int'(idx)*chunk +: chunk] = slice_r;
  end

  always_ff @(posedge clock) begin
    // NOTE: state updates are non-blocking so every register sees pre-edge values.
    if (!reset) begin
      state       <= IDLE;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      s_q         <= '0;
      cout_q      <= 1'b0;
      // NOTE: the wide operand/result registers are cleared too, so a dropped
      // operation leaves nothing behind for the next one.
      opa         <= '0;
      opb         <= '0;
      res         <= '0;
      carry       <= 1'b0;
      idx         <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.in_valid) begin
            opa        <= bus.a;
            opb        <= bus.sub ? ~bus.b : bus.b;
            carry      <= bus.sub | bus.cin;
            idx        <= '0;
            in_ready_q <= 1'b0;
            busy_q     <= 1'b1;
            state      <= ADD;
          end
        end
        ADD: begin
          res   <= res_next;
          carry <= slice_c;
          // The visible result only changes once the top slice is done.
          if (idx == last_idx) begin
            s_q         <= res_next;
            cout_q      <= slice_c;
            out_valid_q <= 1'b1;
            state       <= DONE;
          end else begin
            idx <= idx + 1'b1;
          end
        end
        DONE: begin
          if (bus.out_ready) begin
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            in_ready_q  <= 1'b1;
            state       <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.busy      = busy_q;
  assign bus.s         = s_q;
  assign bus.cout      = cout_q;
endmodule
